// File: rtl/xc_malu_arbiter.sv
// xc_malu_arbiter: shares one multi-cycle xc_malu between two requesters with
// round-robin grant, control-word screening, per-requester abort and a watchdog.
module xc_malu_arbiter #(
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned CW      = 7
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [95:0] req0_ops,
  input  logic [95:0] req1_ops,
  input  logic [16:0] req0_ctl,
  input  logic [16:0] req1_ctl,
  input  logic [1:0]  req_abort,
  output logic [1:0]  rsp_valid,
  input  logic [1:0]  rsp_ready,
  output logic [63:0] rsp_result,
  output logic        rsp_err,
  output logic        malu_valid,
  output logic [31:0] malu_rs1,
  output logic [31:0] malu_rs2,
  output logic [31:0] malu_rs3,
  output logic [8:0]  malu_uop,
  output logic [2:0]  malu_mod,
  output logic [4:0]  malu_pw,
  output logic        malu_flush,
  input  logic [63:0] malu_result,
  input  logic        malu_ready
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

  function automatic logic onehot9(input logic [8:0] v);
    return (v != 9'd0) && ((v & (v - 9'd1)) == 9'd0);
  endfunction

  function automatic logic onehot5(input logic [4:0] v);
    return (v != 5'd0) && ((v & (v - 5'd1)) == 5'd0);
  endfunction

  state_e        state_q, state_d;
  logic          owner_q, owner_d;
  logic          last_grant_q, last_grant_d;
  logic [CW-1:0] count_q, count_d;
  logic [95:0]   ops_q, ops_d;
  logic [16:0]   ctl_q, ctl_d;
  logic [63:0]   rsp_result_q, rsp_result_d;
  logic          rsp_err_q, rsp_err_d;
  logic [1:0]    rsp_valid_q, rsp_valid_d;
  logic          malu_valid_q, malu_valid_d;

  logic [1:0]    grant_s;
  logic          grant_idx_s;
  logic [95:0]   sel_ops_s;
  logic [16:0]   sel_ctl_s;
  logic          legal_s;
  logic          abort_own_s;
  logic          take_own_s;

  // Round-robin pick: on contention the requester not served last time wins.
  always_comb begin
    grant_s = 2'b00;
    case (req_valid)
      2'b01:   grant_s = 2'b01;
      2'b10:   grant_s = 2'b10;
      2'b11:   grant_s = last_grant_q ? 2'b01 : 2'b10;
      default: grant_s = 2'b00;
    endcase
  end

  assign grant_idx_s = grant_s[1];
  assign sel_ops_s   = grant_idx_s ? req1_ops : req0_ops;
  assign sel_ctl_s   = grant_idx_s ? req1_ctl : req0_ctl;
  assign legal_s     = onehot9(sel_ctl_s[16:8]) && onehot5(sel_ctl_s[4:0]);
  assign abort_own_s = req_abort[owner_q];
  assign take_own_s  = rsp_ready[owner_q];
  assign req_ready   = (resetn && (state_q == ST_IDLE)) ? grant_s : 2'b00;

  // Next-state logic; the flush is decided in the same cycle the MALU op ends.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    count_d      = count_q;
    ops_d        = ops_q;
    ctl_d        = ctl_q;
    rsp_result_d = rsp_result_q;
    rsp_err_d    = rsp_err_q;
    malu_flush   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (grant_s != 2'b00) begin
          owner_d      = grant_idx_s;
          last_grant_d = grant_idx_s;
          ops_d        = sel_ops_s;
          ctl_d        = sel_ctl_s;
          count_d      = {CW{1'b0}};
          if (legal_s) begin
            state_d = ST_BUSY;
          end else begin
            state_d      = ST_RESP;
            rsp_result_d = 64'd0;
            rsp_err_d    = 1'b1;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (abort_own_s) begin
          malu_flush = 1'b1;
          state_d    = ST_IDLE;
        end else if (malu_ready) begin
          malu_flush   = 1'b1;
          rsp_result_d = malu_result;
          rsp_err_d    = 1'b0;
          state_d      = ST_RESP;
        end else if (count_q == TO_LAST) begin
          malu_flush   = 1'b1;
          rsp_result_d = 64'd0;
          rsp_err_d    = 1'b1;
          state_d      = ST_RESP;
        end else begin
          count_d = count_q + CW'(1'b1);
        end
      end
      ST_RESP: begin
        // Abort and consume both retire the response; abort simply drops it.
        if (abort_own_s || take_own_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RESP;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    malu_valid_d = (state_d == ST_BUSY);
    rsp_valid_d  = (state_d == ST_RESP) ? (owner_d ? 2'b10 : 2'b01) : 2'b00;
  end

  // State and registered outputs, synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q      <= ST_IDLE;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      count_q      <= {CW{1'b0}};
      ops_q        <= 96'd0;
      ctl_q        <= 17'd0;
      rsp_result_q <= 64'd0;
      rsp_err_q    <= 1'b0;
      rsp_valid_q  <= 2'b00;
      malu_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      count_q      <= count_d;
      ops_q        <= ops_d;
      ctl_q        <= ctl_d;
      rsp_result_q <= rsp_result_d;
      rsp_err_q    <= rsp_err_d;
      rsp_valid_q  <= rsp_valid_d;
      malu_valid_q <= malu_valid_d;
    end
  end

  assign rsp_valid  = rsp_valid_q;
  assign rsp_result = rsp_result_q;
  assign rsp_err    = rsp_err_q;
  assign malu_valid = malu_valid_q;
  assign malu_rs1   = ops_q[31:0];
  assign malu_rs2   = ops_q[63:32];
  assign malu_rs3   = ops_q[95:64];
  assign malu_uop   = ctl_q[16:8];
  assign malu_mod   = ctl_q[7:5];
  assign malu_pw    = ctl_q[4:0];

endmodule

// File: tb/tb_xc_malu_arbiter.sv
// Bench for xc_malu_arbiter: directed scenarios plus randomized transactions,
// each scored against an outcome model of the grant/abort/timeout rules.
module tb_xc_malu_arbiter;
  localparam int TO = 8;

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic [1:0]  req_valid = 2'b00;
  logic [1:0]  req_ready;
  logic [95:0] req0_ops = 96'd0;
  logic [95:0] req1_ops = 96'd0;
  logic [16:0] req0_ctl = 17'd0;
  logic [16:0] req1_ctl = 17'd0;
  logic [1:0]  req_abort = 2'b00;
  logic [1:0]  rsp_valid;
  logic [1:0]  rsp_ready = 2'b00;
  logic [63:0] rsp_result;
  logic        rsp_err;
  logic        malu_valid;
  logic [31:0] malu_rs1, malu_rs2, malu_rs3;
  logic [8:0]  malu_uop;
  logic [2:0]  malu_mod;
  logic [4:0]  malu_pw;
  logic        malu_flush;
  logic [63:0] malu_result = 64'd0;
  logic        malu_ready = 1'b0;

  int total = 0;
  int bad = 0;
  int exp_last = 1;

  always #5 clock = ~clock;

  xc_malu_arbiter #(.TIMEOUT(TO), .CW(4)) dut (
    .clock(clock), .resetn(resetn),
    .req_valid(req_valid), .req_ready(req_ready),
    .req0_ops(req0_ops), .req1_ops(req1_ops),
    .req0_ctl(req0_ctl), .req1_ctl(req1_ctl),
    .req_abort(req_abort),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_err(rsp_err),
    .malu_valid(malu_valid),
    .malu_rs1(malu_rs1), .malu_rs2(malu_rs2), .malu_rs3(malu_rs3),
    .malu_uop(malu_uop), .malu_mod(malu_mod), .malu_pw(malu_pw),
    .malu_flush(malu_flush),
    .malu_result(malu_result), .malu_ready(malu_ready)
  );

  // Toy MALU datapath: unsigned 32x32 multiply for mul, a mixing function otherwise.
  function automatic logic [63:0] malu_fn(input logic [95:0] ops, input logic [8:0] uop);
    if (uop == 9'b001000000) return {32'd0, ops[31:0]} * {32'd0, ops[63:32]};
    return {ops[95:64] ^ ops[31:0], ops[63:32] + ops[31:0]};
  endfunction

  // kind 0 = legal; 1..4 = distinct malformed encodings.
  function automatic logic [16:0] make_ctl(input int kind);
    logic [8:0] u;
    logic [4:0] p;
    u = 9'd1 << $urandom_range(8, 0);
    p = 5'd1 << $urandom_range(4, 0);
    case (kind)
      1: u = 9'd0;
      2: p = 5'd0;
      3: u = 9'd3 << $urandom_range(7, 0);
      4: p = 5'd3 << $urandom_range(3, 0);
      default: ;
    endcase
    return {u, 3'($urandom), p};
  endfunction

  function automatic int exp_grant(input logic [1:0] v);
    if (v == 2'b01) return 0;
    if (v == 2'b10) return 1;
    return 1 - exp_last;
  endfunction

  // Plays the MALU while malu_valid is high; reports what it observed.
  task automatic busy_phase(input int lat, input int abort_at, input logic [1:0] abort_mask,
                            output int ncyc, output int nflush, output int fcyc,
                            output logic [95:0] ops_seen, output logic [16:0] ctl_seen,
                            output bit stable, output bit rdy_seen);
    ncyc = 0; nflush = 0; fcyc = 0; stable = 1'b1; rdy_seen = 1'b0;
    ops_seen = {malu_rs3, malu_rs2, malu_rs1};
    ctl_seen = {malu_uop, malu_mod, malu_pw};
    while (malu_valid === 1'b1 && ncyc < 40) begin
      ncyc++;
      malu_ready  = (ncyc == lat);
      malu_result = (ncyc == lat) ? malu_fn({malu_rs3, malu_rs2, malu_rs1}, malu_uop)
                                  : {$urandom, $urandom};
      req_abort   = (ncyc == abort_at) ? abort_mask : 2'b00;
      #1;
      if (malu_flush === 1'b1) begin nflush++; fcyc = ncyc; end
      if ({malu_rs3, malu_rs2, malu_rs1} !== ops_seen ||
          {malu_uop, malu_mod, malu_pw} !== ctl_seen) stable = 1'b0;
      if (req_ready !== 2'b00) rdy_seen = 1'b1;
      @(posedge clock); #1;
      malu_ready = 1'b0;
      req_abort  = 2'b00;
    end
  endtask

  // One complete transaction from grant to retirement, checked against the model.
  task automatic txn(input string tag, input logic [1:0] v, input int lat, input int abort_at,
                     input logic [1:0] abort_mask, input int resp_wait, input bit resp_abort,
                     input bit keep_valid);
    int g, endc, kind, ncyc, nflush, fcyc;
    logic [1:0] gm;
    logic [95:0] ops, os;
    logic [16:0] ctl, cs;
    logic [63:0] exp_res;
    bit legal, exp_err, stable, rdy_seen;
    g   = exp_grant(v);
    gm  = (g == 0) ? 2'b01 : 2'b10;
    ops = (g == 1) ? req1_ops : req0_ops;
    ctl = (g == 1) ? req1_ctl : req0_ctl;
    legal = ($countones(ctl[16:8]) == 1) && ($countones(ctl[4:0]) == 1);
    req_valid = v;
    #1;
    total++;
    if (req_ready !== gm) begin
      bad++; $display("FAIL %s grant: req_ready=%b expected=%b", tag, req_ready, gm);
    end
    exp_last = g;
    @(posedge clock); #1;
    if (!keep_valid) req_valid = 2'b00;
    kind = 3;
    if (legal) begin
      busy_phase(lat, abort_at, abort_mask, ncyc, nflush, fcyc, os, cs, stable, rdy_seen);
      endc = TO; kind = 2;
      if (lat > 0 && lat <= endc) begin endc = lat; kind = 1; end
      if (abort_at > 0 && abort_mask[g] && abort_at <= endc) begin endc = abort_at; kind = 0; end
      total++;
      if (ncyc != endc || nflush != 1 || fcyc != endc) begin
        bad++; $display("FAIL %s busy: cycles=%0d flushes=%0d flush_at=%0d expected cycles=%0d one flush at %0d",
                        tag, ncyc, nflush, fcyc, endc, endc);
      end
      total++;
      if (os !== ops || cs !== ctl || !stable) begin
        bad++; $display("FAIL %s latch: ops=%h ctl=%h stable=%0d expected ops=%h ctl=%h stable=1",
                        tag, os, cs, stable, ops, ctl);
      end
      total++;
      if (rdy_seen) begin bad++; $display("FAIL %s busy_ready: req_ready seen=1 expected 0", tag); end
    end else begin
      total++;
      if (malu_valid !== 1'b0 || malu_flush !== 1'b0) begin
        bad++; $display("FAIL %s illegal_malu: valid=%b flush=%b expected 0 0", tag, malu_valid, malu_flush);
      end
    end
    exp_res = (kind == 1) ? malu_fn(ops, ctl[16:8]) : 64'd0;
    exp_err = (kind != 1);
    if (kind == 0) begin
      total++;
      if (rsp_valid !== 2'b00 || malu_valid !== 1'b0) begin
        bad++; $display("FAIL %s abort: rsp_valid=%b malu_valid=%b expected 00 0", tag, rsp_valid, malu_valid);
      end
    end else begin
      for (int i = 0; i <= resp_wait; i++) begin
        if (i == resp_wait) begin
          rsp_ready = resp_abort ? 2'b11 : gm;
          req_abort = resp_abort ? gm : 2'b00;
        end else begin
          rsp_ready = 2'($urandom) & ~gm;
          req_abort = 2'($urandom) & ~gm;
        end
        #1;
        total++;
        if (rsp_valid !== gm || rsp_result !== exp_res || rsp_err !== exp_err) begin
          bad++; $display("FAIL %s resp: valid=%b result=%h err=%b expected %b %h %b",
                          tag, rsp_valid, rsp_result, rsp_err, gm, exp_res, exp_err);
        end
        total++;
        if (malu_valid !== 1'b0 || malu_flush !== 1'b0 || req_ready !== 2'b00) begin
          bad++; $display("FAIL %s resp_quiet: malu_valid=%b flush=%b req_ready=%b expected 0 0 00",
                          tag, malu_valid, malu_flush, req_ready);
        end
        @(posedge clock); #1;
        rsp_ready = 2'b00;
        req_abort = 2'b00;
      end
      total++;
      if (rsp_valid !== 2'b00) begin
        bad++; $display("FAIL %s retire: rsp_valid=%b expected 00", tag, rsp_valid);
      end
    end
  endtask

  task automatic test_reset;
    resetn = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    req_valid = 2'b11;
    #1;
    total++;
    if (req_ready !== 2'b00) begin bad++; $display("FAIL reset_ready: req_ready=%b expected 00", req_ready); end
    total++;
    if (rsp_valid !== 2'b00 || rsp_result !== 64'd0 || rsp_err !== 1'b0) begin
      bad++; $display("FAIL reset_rsp: valid=%b result=%h err=%b expected 00 0 0", rsp_valid, rsp_result, rsp_err);
    end
    total++;
    if (malu_valid !== 1'b0 || malu_flush !== 1'b0 || {malu_rs3, malu_rs2, malu_rs1} !== 96'd0 ||
        {malu_uop, malu_mod, malu_pw} !== 17'd0) begin
      bad++; $display("FAIL reset_malu: valid=%b flush=%b ops=%h ctl=%h expected all 0",
                      malu_valid, malu_flush, {malu_rs3, malu_rs2, malu_rs1}, {malu_uop, malu_mod, malu_pw});
    end
    req_valid = 2'b00;
    resetn = 1'b1;
    exp_last = 1;
    @(posedge clock); #1;
  endtask

  task automatic test_single;
    req0_ops = {32'd0, 32'd6, 32'd7};
    req0_ctl = {9'b001000000, 3'b000, 5'b10000};
    total++;
    if (malu_fn(req0_ops, req0_ctl[16:8]) !== 64'd42) begin
      bad++; $display("FAIL single_model: product=%0d expected 42", malu_fn(req0_ops, req0_ctl[16:8]));
    end
    txn("single", 2'b01, 5, 0, 2'b00, 0, 1'b0, 1'b0);
  endtask

  task automatic test_contention;
    req0_ops = {$urandom, $urandom, $urandom}; req0_ctl = make_ctl(0);
    req1_ops = {$urandom, $urandom, $urandom}; req1_ctl = make_ctl(0);
    for (int i = 0; i < 4; i++) txn("contention", 2'b11, $urandom_range(6, 1), 0, 2'b00, 0, 1'b0, 1'b1);
    req_valid = 2'b00;
  endtask

  task automatic test_illegal;
    req1_ops = {$urandom, $urandom, $urandom};
    req1_ctl = {9'b000110000, 3'b000, 5'b10000};
    txn("illegal_uop", 2'b10, 3, 0, 2'b00, 2, 1'b0, 1'b0);
    req0_ctl = make_ctl(2);
    txn("illegal_pw", 2'b01, 3, 0, 2'b00, 0, 1'b0, 1'b0);
  endtask

  task automatic test_timeout;
    req0_ctl = make_ctl(0);
    req1_ctl = make_ctl(0);
    txn("timeout", 2'b01, 0, 0, 2'b00, 1, 1'b0, 1'b0);
    txn("ready_at_limit", 2'b10, TO, 0, 2'b00, 0, 1'b0, 1'b0);
  endtask

  task automatic test_abort;
    txn("abort_with_ready", 2'b01, 3, 3, 2'b01, 0, 1'b0, 1'b0);
    txn("nonowner_abort", 2'b10, 4, 2, 2'b01, 0, 1'b0, 1'b0);
    txn("resp_abort", 2'b01, 2, 0, 2'b00, 1, 1'b1, 1'b0);
    txn("abort_at_limit", 2'b10, 0, TO, 2'b11, 0, 1'b0, 1'b0);
  endtask

  task automatic test_backpressure;
    txn("backpressure", 2'b11, 3, 0, 2'b00, 10, 1'b0, 1'b1);
    req_valid = 2'b00;
  endtask

  task automatic test_reset_mid;
    req0_ctl = make_ctl(0);
    req_valid = 2'b01;
    @(posedge clock); #1;
    req_valid = 2'b00;
    @(posedge clock); #1;
    resetn = 1'b0;
    @(posedge clock); #1;
    exp_last = 1;
    req_valid = 2'b11;
    #1;
    total++;
    if (req_ready !== 2'b00 || rsp_valid !== 2'b00 || rsp_result !== 64'd0 || rsp_err !== 1'b0) begin
      bad++; $display("FAIL midreset_rsp: ready=%b valid=%b result=%h err=%b expected 00 00 0 0",
                      req_ready, rsp_valid, rsp_result, rsp_err);
    end
    total++;
    if (malu_valid !== 1'b0 || malu_flush !== 1'b0 || {malu_rs3, malu_rs2, malu_rs1} !== 96'd0 ||
        {malu_uop, malu_mod, malu_pw} !== 17'd0) begin
      bad++; $display("FAIL midreset_malu: valid=%b flush=%b ops=%h expected all 0",
                      malu_valid, malu_flush, {malu_rs3, malu_rs2, malu_rs1});
    end
    req_valid = 2'b00;
    resetn = 1'b1;
    @(posedge clock); #1;
    txn("after_reset", 2'b11, 2, 0, 2'b00, 0, 1'b0, 1'b0);
  endtask

  task automatic test_random;
    for (int n = 0; n < 30; n++) begin
      req0_ops = {$urandom, $urandom, $urandom};
      req1_ops = {$urandom, $urandom, $urandom};
      req0_ctl = make_ctl(($urandom_range(7, 0) == 0) ? $urandom_range(4, 1) : 0);
      req1_ctl = make_ctl(($urandom_range(7, 0) == 0) ? $urandom_range(4, 1) : 0);
      txn("random", 2'($urandom_range(3, 1)), $urandom_range(TO + 2, 0),
          ($urandom_range(3, 0) == 0) ? $urandom_range(TO + 1, 1) : 0, 2'($urandom),
          $urandom_range(3, 0), ($urandom_range(4, 0) == 0), 1'($urandom));
      req_valid = 2'b00;
    end
  endtask

  initial begin
    test_reset;
    test_single;
    test_contention;
    test_illegal;
    test_timeout;
    test_abort;
    test_backpressure;
    test_reset_mid;
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/xc_malu_arbiter.md
Name: xc_malu_arbiter

Overview:
Shares one xc_malu multi-cycle multiply/divide unit between two requesters (e.g. two issue ports).
- Arbitrates round-robin and latches the granted operation.
- Drives the MALU valid/flush handshake and returns the 64-bit result to the owning requester.
- Rejects malformed micro-op encodings without using the MALU.
- Provides per-requester abort and a watchdog timeout.

Parameters:
- TIMEOUT, 64, max BUSY cycles waiting for malu_ready before forced abort (>=2).
- CW, 7, timeout counter width; must satisfy 2^CW >= TIMEOUT.

Ports:
- clock  in  1  clock.
- resetn  in  1  reset, synchronous, active-low.
- req_valid  in  2  request valid, bit i = requester i.
- req_ready  out  2  request accepted this cycle (combinational).
- req0_ops  in  96  {rs3,rs2,rs1} for requester 0.
- req1_ops  in  96  {rs3,rs2,rs1} for requester 1.
- req0_ctl  in  17  requester 0 control. Bits 16:8 = uop {div,rem,mul,pmul,madd,msub_1,msub_2,macc_1,macc_2}; bits 7:5 = {lh_sign,rh_sign,carryless}; bits 4:0 = pw {32,16,8,4,2}.
- req1_ctl  in  17  requester 1 control, same layout as req0_ctl.
- req_abort  in  2  cancel the in-flight operation of requester i.
- rsp_valid  out  2  response valid for requester i (at most one bit set).
- rsp_ready  in  2  requester i consumes the response.
- rsp_result  out  64  response result.
- rsp_err  out  1  1 = illegal control or timeout; rsp_result is then 0.
- malu_valid  out  1  MALU inputs valid.
- malu_rs1, malu_rs2, malu_rs3  out  32 each  latched operands.
- malu_uop  out  9  latched uop field, same order as ctl.
- malu_mod  out  3  latched mod field.
- malu_pw  out  5  latched pw field.
- malu_flush  out  1  single-cycle flush of MALU state.
- malu_result  in  64  MALU result.
- malu_ready  in  1  MALU result valid.

Behaviour:
- Reset: state=IDLE, owner=0, last_grant=1 (requester 0 has first priority), counter=0.
- Outputs at reset: req_ready=0, rsp_valid=0, rsp_result=0, rsp_err=0, malu_valid=0, malu_flush=0, all latched malu_* operand/control outputs=0.
- States: IDLE, BUSY, RESP.

IDLE:
- If exactly one req_valid is set, grant it.
- If both are set, grant the requester != last_grant.
- req_ready[g]=1 combinationally in that cycle only. Latch ops/ctl, owner=g, last_grant=g.
- Legal ctl: uop exactly one-hot AND pw exactly one-hot.
- Legal -> BUSY with counter=0.
- Illegal -> RESP with rsp_err=1, rsp_result=0; the MALU is never touched.
- req_abort is ignored in IDLE.

BUSY:
- malu_valid=1; malu_* held stable for the whole operation.
- req_ready=0 for both requesters.
- Priority: abort > completion > timeout.
- Owner abort (req_abort[owner]=1): malu_flush=1, -> IDLE, no response. Applies even if malu_ready=1 in the same cycle.
- Completion (malu_ready=1): malu_flush=1, capture rsp_result=malu_result and rsp_err=0, -> RESP.
- Timeout (counter==TIMEOUT-1 and malu_ready=0): malu_flush=1, rsp_result=0, rsp_err=1, -> RESP.
- Otherwise counter increments.
- Non-owner abort bit is ignored.

RESP:
- rsp_valid[owner]=1; rsp_result and rsp_err held stable.
- rsp_ready[owner]=1 -> IDLE. New grants start from IDLE, so there is at least one idle cycle between operations.
- req_abort[owner]=1 -> drop the response, -> IDLE. Abort wins over a simultaneous rsp_ready.
- rsp_ready of the non-owner is ignored.

General:
- malu_valid is low in IDLE and RESP.
- malu_flush is high only on the BUSY exit cycle (completion, abort or timeout).
- Latency: grant cycle + MALU latency + 1 capture cycle until rsp_valid.
- Reset mid-operation: return to the reset state on the next edge with no response. The MALU is reset by the same resetn.

Test Plan:
- Single request: req0 mul, unsigned, pw_32, rs1=7, rs2=6; MALU model answers after 5 cycles -> rsp_valid=2'b01, rsp_result=42, rsp_err=0, malu_flush pulses exactly once.
- Contention: both req_valid held high for 4 back-to-back ops -> grants alternate 0,1,0,1; req_ready never 2'b11; results route to the correct rsp_valid bit.
- Illegal ctl: req1 with uop=9'b000110000 -> rsp_valid=2'b10, rsp_err=1, rsp_result=0, malu_valid never asserted.
- Timeout: TIMEOUT=8, MALU model never asserts ready -> malu_flush on BUSY cycle 8, rsp_err=1. Also drive malu_ready exactly on cycle 8 -> normal result, rsp_err=0.
- Abort: req_abort[owner] in the same cycle as malu_ready -> malu_flush=1, no rsp_valid, state IDLE. Non-owner abort has no effect.
- Backpressure/reset: hold rsp_ready=0 for 10 cycles -> result stable and no new grant. Deassert resetn during BUSY -> all outputs 0 and next grant goes to requester 0.
